// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MAR/MDR memory responder
// Purpose: state encoding, word width and default geometry used by
//          mem_responder and mem_array.
// Ports:   none (package).
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  // Wait counter is wide enough for WAIT_STATES up to 15.
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM backing the memory responder
// Purpose: DEPTH x WORD_W storage, write and read both registered on Clock.
//          Read is read-first: rdata shows the word stored before a
//          same-edge write. No reset; contents survive clear.
// Ports:   Clock - rising-edge clock
//          we    - write enable
//          addr  - word address
//          wdata - write data
//          rdata - registered read data
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory slave with programmable wait states
// Purpose: accepts a Read or Write from the CPU datapath in IDLE, latches the
//          address/data/operation, waits WAIT_STATES extra cycles, performs
//          the array access, then pulses MemDone for one cycle.
// Ports:   Clock   - rising-edge clock
//          clear   - asynchronous active-high reset
//          MARaddr - word address, only [ADDR_W-1:0] used (wraps mod DEPTH)
//          MDRdata - write data
//          Read    - read request
//          Write   - write request
//          Mdatain - read data, held until the next completed read
//          MemBusy - high in ACCESS and DONE
//          MemDone - one-cycle completion pulse
//          MemErr  - one-cycle pulse when Read and Write are both high in IDLE
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic [WORD_W-1:0] MARaddr,
  input  logic [WORD_W-1:0] MDRdata,
  input  logic              Read,
  input  logic              Write,
  output logic [WORD_W-1:0] Mdatain,
  output logic              MemBusy,
  output logic              MemDone,
  output logic              MemErr
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              is_write;
  logic [WORD_W-1:0] mdat_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              access_edge;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses wrap mod DEPTH.
  assign unused_addr_hi = ^MARaddr[WORD_W-1:ADDR_W];

  // The edge that ends the last wait cycle is the one that touches the array.
  assign access_edge = (state == ACCESS) && (cnt == WAIT_LAST);
  assign ram_we      = access_edge && is_write;

  mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .Clock (Clock),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_write <= 1'b0;
      mdat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Read && Write) begin
            err_q <= 1'b1;
          end else if (Read || Write) begin
            addr_q   <= MARaddr[ADDR_W-1:0];
            wdata_q  <= MDRdata;
            is_write <= Write;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == WAIT_LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Keep the word that was presented during DONE for later cycles.
          if (!is_write) begin
            mdat_q <= ram_rdata;
          end
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The RAM output register already holds the word read at the access edge,
  // so it is forwarded during DONE; afterwards the held copy is shown. clear
  // drops done_q, so the mux falls back to the zeroed holding register.
  assign Mdatain = (done_q && !is_write) ? ram_rdata : mdat_q;
  assign MemBusy = busy_q;
  assign MemDone = done_q;
  assign MemErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk;
  logic        clear;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rd;
  logic [2:0]  wr;
  logic [31:0] q [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  err;

  int errors = 0;
  int checks = 0;

  int          ws_of [3];
  logic [31:0] model_mem [3][512];
  bit          known [3][512];
  logic [31:0] last_rd [3];
  int          pool [8];

  mem_responder #(.WAIT_STATES(2)) u_ws2 (
    .Clock(clk), .clear(clear), .MARaddr(addr), .MDRdata(wdata),
    .Read(rd[0]), .Write(wr[0]), .Mdatain(q[0]),
    .MemBusy(busy[0]), .MemDone(done[0]), .MemErr(err[0])
  );

  mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .Clock(clk), .clear(clear), .MARaddr(addr), .MDRdata(wdata),
    .Read(rd[1]), .Write(wr[1]), .Mdatain(q[1]),
    .MemBusy(busy[1]), .MemDone(done[1]), .MemErr(err[1])
  );

  mem_responder #(.WAIT_STATES(15)) u_ws15 (
    .Clock(clk), .clear(clear), .MARaddr(addr), .MDRdata(wdata),
    .Read(rd[2]), .Write(wr[2]), .Mdatain(q[2]),
    .MemBusy(busy[2]), .MemDone(done[2]), .MemErr(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request on unit u; checks latency, busy length, data and
  // the idle cycle that follows. Address/data are scrambled right after accept.
  task automatic access(input int u, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int k;
    int nbusy;
    bit seen;
    int idx;
    idx = int'(a % 512);
    @(negedge clk);
    rd[u] = !w; wr[u] = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0; addr = $urandom; wdata = $urandom;
    k = 0; nbusy = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      if (busy[u]) nbusy++;
      if (done[u]) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, k, ws_of[u] + 1);
    chk({tag, "_busy_cycles"}, nbusy, ws_of[u] + 2);
    if (w) begin
      chk({tag, "_hold_on_write"}, q[u], last_rd[u]);
      model_mem[u][idx] = d;
      known[u][idx] = 1'b1;
    end else if (known[u][idx]) begin
      chk({tag, "_rdata"}, q[u], model_mem[u][idx]);
      last_rd[u] = model_mem[u][idx];
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy[u]), 32'd0);
    chk({tag, "_idle_done"}, 32'(done[u]), 32'd0);
    chk({tag, "_idle_hold"}, q[u], last_rd[u]);
  endtask

  initial begin
    logic [5:0] exp_busy;
    logic [5:0] exp_done;
    int k;
    ws_of[0] = 2; ws_of[1] = 0; ws_of[2] = 15;
    for (int u = 0; u < 3; u++) begin
      last_rd[u] = '0;
      for (int i = 0; i < 512; i++) known[u][i] = 1'b0;
    end
    clear = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0;

    // Reset state
    #3;
    for (int u = 0; u < 3; u++) begin
      chk("reset_mdatain", q[u], 32'd0);
      chk("reset_busy", 32'(busy[u]), 32'd0);
      chk("reset_done", 32'(done[u]), 32'd0);
      chk("reset_err", 32'(err[u]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;

    // Basic write/read and address wrap
    access(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, "wr5");
    access(0, 1'b0, 32'h0000_0005, 32'h0, "rd5");
    access(0, 1'b0, 32'h0000_0205, 32'h0, "rd205_wrap");

    // Read and Write together: error pulse only
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; addr = 32'h5; wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0;
    chk("err_pulse", 32'(err[0]), 32'd1);
    chk("err_busy", 32'(busy[0]), 32'd0);
    chk("err_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err[0]), 32'd0);
    chk("err_busy2", 32'(busy[0]), 32'd0);
    access(0, 1'b0, 32'h0000_0005, 32'h0, "rd5_after_err");

    // clear during a write: async return to reset values, array untouched
    access(0, 1'b1, 32'h0000_0010, 32'hA5A5_0010, "wr10_old");
    @(negedge clk);
    wr[0] = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    wr[0] = 1'b0;
    chk("clr_pre_busy", 32'(busy[0]), 32'd1);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_async_mdatain", q[0], 32'd0);
    chk("clr_async_busy", 32'(busy[0]), 32'd0);
    chk("clr_async_done", 32'(done[0]), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    for (int u = 0; u < 3; u++) last_rd[u] = '0;
    chk("clr_release_busy", 32'(busy[0]), 32'd0);
    access(0, 1'b0, 32'h0000_0010, 32'h0, "rd10_after_clear");

    // Read held through DONE is re-accepted at the first IDLE edge
    exp_busy = 6'b101111;
    exp_done = 6'b001000;
    @(negedge clk);
    rd[0] = 1'b1; addr = 32'h5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("held_busy_%0d", i), 32'(busy[0]), 32'(exp_busy[i]));
      chk($sformatf("held_done_%0d", i), 32'(done[0]), 32'(exp_done[i]));
      if (i == 3) chk("held_rdata", q[0], 32'hDEAD_BEEF);
    end
    rd[0] = 1'b0;
    k = 0;
    while (!done[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("held_reaccept_latency", k, 3);
    chk("held_reaccept_rdata", q[0], 32'hDEAD_BEEF);
    last_rd[0] = 32'hDEAD_BEEF;
    @(negedge clk);

    // Randomized traffic against the reference model
    for (int p = 0; p < 8; p++) begin
      pool[p] = int'($urandom_range(0, 511));
      access(0, 1'b1, 32'(pool[p]), $urandom, "rnd_init");
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      int p;
      p = int'($urandom_range(0, 7));
      ra = ($urandom & 32'hFFFF_FE00) | 32'(pool[p]);
      access(0, 1'($urandom_range(0, 1)), ra, $urandom, "rnd");
    end

    // Wait-state extremes
    access(1, 1'b1, 32'h0000_0007, 32'hCAFE_0007, "ws0_wr");
    access(1, 1'b0, 32'h0000_0007, 32'h0, "ws0_rd");
    access(2, 1'b1, 32'h0000_01FF, 32'hF00D_01FF, "ws15_wr");
    access(2, 1'b0, 32'hFFFF_FFFF, 32'h0, "ws15_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
